// File: rtl/p_instruction.sv
// Shared instruction-field types: the decoder's e_cond encoding and the NZCV flag layout.
package p_instruction;

   typedef enum logic [3:0] {
      EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
      MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
      HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
      GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
   } e_cond;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } t_flags;

   localparam t_flags FLAGS_RESET = 4'b0000;

   // AL and NV ignore the flags, so they never wait on an in-flight writer.
   function automatic logic f_is_unconditional(input e_cond i_c);
      return (i_c == AL) || (i_c == NV);
   endfunction

endpackage

// File: rtl/m_cond_check.sv
// Combinational condition evaluator: (e_cond, NZCV) -> truth. Shared with the branch unit.
module m_cond_check
   import p_instruction::*;
(
   input  e_cond  i_cond,
   input  t_flags i_flags,
   output logic   o_truth
);

   always_comb begin
      o_truth = 1'b0;
      case (i_cond)
         EQ: o_truth = i_flags.z;
         NE: o_truth = !i_flags.z;
         CS: o_truth = i_flags.c;
         CC: o_truth = !i_flags.c;
         MI: o_truth = i_flags.n;
         PL: o_truth = !i_flags.n;
         VS: o_truth = i_flags.v;
         VC: o_truth = !i_flags.v;
         HI: o_truth = i_flags.c && !i_flags.z;
         LS: o_truth = !i_flags.c || i_flags.z;
         GE: o_truth = (i_flags.n == i_flags.v);
         LT: o_truth = (i_flags.n != i_flags.v);
         GT: o_truth = !i_flags.z && (i_flags.n == i_flags.v);
         LE: o_truth = i_flags.z || (i_flags.n != i_flags.v);
         AL: o_truth = 1'b1;
         NV: o_truth = 1'b0;
         default: o_truth = 1'b0;
      endcase
   end

endmodule

// File: rtl/m_cond_eval.sv
// Execute-stage head: holds NZCV, scoreboards in-flight flag writers, emits exec/squash.
// Optional build macro MARISCAL_COND_NV_FAULT_EN: accepted NV ops raise out_fault.
module m_cond_eval
   import p_instruction::*;
#(
   parameter int TAG_W       = 6,
   parameter int MAX_PENDING = 3
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cond,
   input  logic             in_set_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_exec,
   output logic             out_fault,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flags_wr_en,
   input  logic [3:0]       flags_wr_val,
   input  logic             flush,
   output logic [3:0]       flags
);

   localparam int              PEND_W   = $clog2(MAX_PENDING + 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   t_flags              r_flags;
   logic [PEND_W-1:0]   r_pend;
   logic                r_valid_p1;
   logic                r_exec_p1;
   logic [TAG_W-1:0]    r_tag_p1;

   e_cond   w_cond;
   t_flags  w_fe;
   logic    w_truth;
   logic    w_final;
   logic    w_cond_haz;
   logic    w_full_haz;
   logic    w_accept;
   logic    w_inc;
   logic    w_dec;

   assign w_cond = e_cond'(in_cond);
   // Forward a same-cycle commit so a dependent op need not wait an extra cycle.
   assign w_fe   = flags_wr_en ? t_flags'(flags_wr_val) : r_flags;

   m_cond_check u_cond_check (
      .i_cond  (w_cond),
      .i_flags (w_fe),
      .o_truth (w_truth)
   );

   assign w_final    = (r_pend == '0) || ((r_pend == PEND_ONE) && flags_wr_en);
   assign w_cond_haz = in_valid && !f_is_unconditional(w_cond) && !w_final;
   assign w_full_haz = in_valid && in_set_flags && (r_pend == PEND_MAX) && !flags_wr_en;

   assign in_ready = rst_n && (!r_valid_p1 || out_ready) && !w_cond_haz
                     && !w_full_haz && !flush;
   assign w_accept = in_valid && in_ready;

   assign w_inc = w_accept && in_set_flags && w_truth;
   assign w_dec = flags_wr_en;

   // Architectural flags and writer scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= FLAGS_RESET;
         r_pend  <= '0;
      end else begin
         if (flags_wr_en)
            r_flags <= t_flags'(flags_wr_val);
         if (flush)
            r_pend <= '0;
         else if (w_inc && !w_dec)
            r_pend <= r_pend + PEND_ONE;
         else if (w_dec && !w_inc && (r_pend != '0))
            r_pend <= r_pend - PEND_ONE;
      end
   end

   // Stage p1: registered decision toward execute
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_p1 <= 1'b0;
         r_exec_p1  <= 1'b0;
         r_tag_p1   <= '0;
      end else if (flush) begin
         r_valid_p1 <= 1'b0;
      end else if (w_accept) begin
         r_valid_p1 <= 1'b1;
         r_exec_p1  <= w_truth;
         r_tag_p1   <= in_tag;
      end else if (out_ready) begin
         r_valid_p1 <= 1'b0;
      end
   end

`ifdef MARISCAL_COND_NV_FAULT_EN
   logic r_fault_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_fault_p1 <= 1'b0;
      else if (!flush && w_accept)
         r_fault_p1 <= (w_cond == NV);
   end

   assign out_fault = r_fault_p1;
`else
   assign out_fault = 1'b0;
`endif

   assign out_valid = r_valid_p1;
   assign out_exec  = r_exec_p1;
   assign out_tag   = r_tag_p1;
   assign flags     = r_flags;

endmodule

// File: tb/tb_m_cond_eval.sv
// Self-checking bench for m_cond_eval: directed scenarios plus randomized traffic vs a reference model.
module tb_m_cond_eval;

   localparam int TAG_W       = 6;
   localparam int MAX_PENDING = 3;
`ifdef MARISCAL_COND_NV_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_cond;
   logic             in_set_flags;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic             out_exec;
   logic             out_fault;
   logic [TAG_W-1:0] out_tag;
   logic             flags_wr_en;
   logic [3:0]       flags_wr_val;
   logic             flush;
   logic [3:0]       flags;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [3:0]       m_flags;
   int               m_pend;
   bit               m_ov, m_oe, m_of;
   logic [TAG_W-1:0] m_otag;

   always #5 clk = ~clk;

   m_cond_eval #(.TAG_W(TAG_W), .MAX_PENDING(MAX_PENDING)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_cond      (in_cond),
      .in_set_flags (in_set_flags),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_exec     (out_exec),
      .out_fault    (out_fault),
      .out_tag      (out_tag),
      .flags_wr_en  (flags_wr_en),
      .flags_wr_val (flags_wr_val),
      .flush        (flush),
      .flags        (flags)
   );

   // ARM encoding: pairs of (cond, !cond); bit 0 selects the inverse.
   function automatic bit ref_truth(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic bit model_ready();
      bit final_f, ch, fh;
      final_f = (m_pend == 0) || (m_pend == 1 && flags_wr_en);
      ch = in_valid && (in_cond < 4'd14) && !final_f;
      fh = in_valid && in_set_flags && (m_pend == MAX_PENDING) && !flags_wr_en;
      return (!m_ov || out_ready) && !ch && !fh && !flush;
   endfunction

   // Advance the model by one clock using the inputs currently driven, then wait past the edge.
   task automatic advance();
      bit rdy, acc, tr, inc;
      logic [3:0] fe;
      fe  = flags_wr_en ? flags_wr_val : m_flags;
      rdy = model_ready();
      acc = in_valid && rdy;
      tr  = ref_truth(in_cond, fe);
      if (flags_wr_en) m_flags = flags_wr_val;
      if (flush) begin
         m_pend = 0;
         m_ov   = 1'b0;
      end else begin
         inc = acc && in_set_flags && tr;
         if (inc && flags_wr_en) m_pend = m_pend;
         else if (inc) m_pend = m_pend + 1;
         else if (flags_wr_en && m_pend > 0) m_pend = m_pend - 1;
         if (acc) begin
            m_ov   = 1'b1;
            m_oe   = tr;
            m_otag = in_tag;
            m_of   = FAULT_EN && (in_cond == 4'd15);
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid     = 1'b0;
      in_cond      = 4'd14;
      in_set_flags = 1'b0;
      in_tag       = '0;
      out_ready    = 1'b1;
      flags_wr_en  = 1'b0;
      flags_wr_val = 4'd0;
      flush        = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      in_valid = 1'b1;
      m_flags = 4'd0; m_pend = 0; m_ov = 0; m_oe = 0; m_of = 0; m_otag = '0;
      @(negedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      vectors++;
      if ({out_valid, out_exec, out_fault} !== 3'b000 || out_tag !== '0 || flags !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b e=%b f=%b tag=%0d flags=%b want all zero",
                  out_valid, out_exec, out_fault, out_tag, flags);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
   endtask

   task automatic test_eq_forward();
      @(negedge clk);
      in_valid = 1'b1; in_cond = 4'd0; in_tag = 6'd1;
      flags_wr_en = 1'b1; flags_wr_val = 4'b0100;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL eq_fwd_ready: got %b want 1", in_ready);
      end
      advance();
      vectors++;
      if (out_valid !== 1'b1 || out_exec !== 1'b1 || flags !== 4'b0100 || out_tag !== 6'd1) begin
         miscompares++;
         $display("FAIL eq_fwd_result: got v=%b e=%b flags=%b tag=%0d want v=1 e=1 flags=0100 tag=1",
                  out_valid, out_exec, flags, out_tag);
      end
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_cond_stall();
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_tag = 6'd2;
      advance();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle();
         in_valid = 1'b1; in_cond = 4'd1; in_tag = 6'd3;
         #1;
         vectors++;
         if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cond_stall_wait%0d: in_ready got %b want 0", i, in_ready);
         end
         advance();
      end
      @(negedge clk);
      flags_wr_en = 1'b1; flags_wr_val = 4'b0000;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL cond_stall_release: in_ready got %b want 1", in_ready);
      end
      advance();
      vectors++;
      if (out_valid !== 1'b1 || out_exec !== 1'b1 || out_tag !== 6'd3 || flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL cond_stall_result: got v=%b e=%b tag=%0d flags=%b want v=1 e=1 tag=3 flags=0000",
                  out_valid, out_exec, out_tag, flags);
      end
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_full();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_tag = 6'(10 + i);
         #1;
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_fill%0d: in_ready got %b want 1", i, in_ready);
         end
         advance();
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_tag = 6'd13;
         #1;
         vectors++;
         if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_stall%0d: in_ready got %b want 0", i, in_ready);
         end
         advance();
      end
      @(negedge clk);
      flags_wr_en = 1'b1; flags_wr_val = 4'b0010;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL full_release: in_ready got %b want 1", in_ready);
      end
      advance();
      vectors++;
      if (out_valid !== 1'b1 || out_tag !== 6'd13 || out_exec !== 1'b1) begin
         miscompares++;
         $display("FAIL full_result: got v=%b tag=%0d e=%b want v=1 tag=13 e=1", out_valid, out_tag, out_exec);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         flags_wr_en = 1'b1; flags_wr_val = 4'b0010;
         advance();
      end
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd2; in_tag = 6'd14;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL full_drained: in_ready got %b want 1", in_ready);
      end
      advance();
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd14; in_tag = 6'd5;
      advance();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         out_ready = 1'b0; in_tag = 6'd6; in_cond = 4'd15;
         #1;
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 6'd5 || out_exec !== 1'b1) begin
            miscompares++;
            $display("FAIL hold%0d: got rdy=%b v=%b tag=%0d e=%b want rdy=0 v=1 tag=5 e=1",
                     i, in_ready, out_valid, out_tag, out_exec);
         end
         advance();
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_release: in_ready got %b want 1", in_ready);
      end
      advance();
      vectors++;
      if (out_valid !== 1'b1 || out_tag !== 6'd6 || out_exec !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_next: got v=%b tag=%0d e=%b want v=1 tag=6 e=0", out_valid, out_tag, out_exec);
      end
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle();
         in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_tag = 6'(20 + i);
         advance();
      end
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd0; in_tag = 6'd22;
      flush = 1'b1; flags_wr_en = 1'b1; flags_wr_val = 4'b1001;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_ready: in_ready got %b want 0", in_ready);
      end
      advance();
      vectors++;
      if (out_valid !== 1'b0 || flags !== 4'b1001) begin
         miscompares++;
         $display("FAIL flush_result: got v=%b flags=%b want v=0 flags=1001", out_valid, flags);
      end
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd0; in_tag = 6'd23;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_pend_cleared: in_ready got %b want 1", in_ready);
      end
      advance();
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_nv();
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd15; in_set_flags = 1'b1; in_tag = 6'd30;
      advance();
      vectors++;
      if (out_valid !== 1'b1 || out_exec !== 1'b0 || out_fault !== FAULT_EN) begin
         miscompares++;
         $display("FAIL nv_result: got v=%b e=%b f=%b want v=1 e=0 f=%b", out_valid, out_exec, out_fault, FAULT_EN);
      end
      @(negedge clk);
      idle();
      in_valid = 1'b1; in_cond = 4'd0; in_tag = 6'd31;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL nv_no_pending: in_ready got %b want 1", in_ready);
      end
      advance();
      vectors++;
      if (out_fault !== 1'b0) begin
         miscompares++;
         $display("FAIL nv_fault_clear: got %b want 0", out_fault);
      end
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_ge_lt();
      bit exp;
      for (int f = 0; f < 16; f++) begin
         @(negedge clk);
         idle();
         in_valid = 1'b1; in_cond = 4'd10; in_tag = 6'(f);
         flags_wr_en = 1'b1; flags_wr_val = 4'(f);
         exp = ref_truth(4'd10, 4'(f));
         advance();
         vectors++;
         if (out_valid !== 1'b1 || out_exec !== exp) begin
            miscompares++;
            $display("FAIL ge_flags%0d: got v=%b e=%b want v=1 e=%b", f, out_valid, out_exec, exp);
         end
         @(negedge clk);
         idle();
         in_valid = 1'b1; in_cond = 4'd11; in_tag = 6'(f);
         exp = ref_truth(4'd11, 4'(f));
         advance();
         vectors++;
         if (out_valid !== 1'b1 || out_exec !== exp) begin
            miscompares++;
            $display("FAIL lt_flags%0d: got v=%b e=%b want v=1 e=%b", f, out_valid, out_exec, exp);
         end
      end
      @(negedge clk);
      idle();
      advance();
   endtask

   task automatic test_random();
      bit exp_rdy;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         in_valid     = ($urandom_range(0, 9) < 7);
         in_cond      = 4'($urandom_range(0, 15));
         in_set_flags = ($urandom_range(0, 9) < 4);
         in_tag       = TAG_W'($urandom);
         out_ready    = ($urandom_range(0, 3) != 0);
         flags_wr_en  = ($urandom_range(0, 9) < 3);
         flags_wr_val = 4'($urandom_range(0, 15));
         flush        = ($urandom_range(0, 19) == 0);
         #1;
         exp_rdy = model_ready();
         vectors++;
         if (in_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL rand_ready@%0d: got %b want %b", i, in_ready, exp_rdy);
         end
         advance();
         vectors++;
         if (out_valid !== m_ov || flags !== m_flags || out_fault !== m_of) begin
            miscompares++;
            $display("FAIL rand_state@%0d: got v=%b flags=%b f=%b want v=%b flags=%b f=%b",
                     i, out_valid, flags, out_fault, m_ov, m_flags, m_of);
         end
         if (m_ov) begin
            vectors++;
            if (out_exec !== m_oe || out_tag !== m_otag) begin
               miscompares++;
               $display("FAIL rand_decision@%0d: got e=%b tag=%0d want e=%b tag=%0d",
                        i, out_exec, out_tag, m_oe, m_otag);
            end
         end
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      test_reset();
      test_eq_forward();
      test_cond_stall();
      test_full();
      test_back_to_back();
      test_flush();
      test_nv();
      test_ge_lt();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
